// File: rtl/uart_mm.sv
// Memory-mapped 8N1 UART: TX FIFO + serialiser, RX deserialiser with one-byte buffer.
// Optional receiver loopback from o_txd when UART_LOOPBACK_EN is defined.
module uart_mm #(
  parameter int unsigned TXFIFO_DEPTH = 4,
  parameter int unsigned DIV_RESET    = 433
) (
  input  logic        i_clk,
  input  logic        i_rstb,
  input  logic [3:0]  i_addr,
  input  logic [31:0] i_din,
  input  logic [3:0]  i_wr_en,
  input  logic        i_rd_en,
  output logic [31:0] o_dout,
  output logic        o_irq,
  output logic        o_txd,
  input  logic        i_rxd
);

  localparam int unsigned AW = $clog2(TXFIFO_DEPTH);

  typedef enum logic [1:0] {ST_IDLE, ST_START, ST_DATA, ST_STOP} state_t;

  logic [1:0]  sel;
  logic        wr_any, wr_data, wr_stat, wr_div, wr_ctrl, rd_data;
  logic [15:0] div_q;
  logic        rx_ie, tx_ie, ctrl_loop;
  logic        unused_bits;

  assign sel         = i_addr[3:2];
  assign wr_any      = |i_wr_en;
  assign wr_data     = wr_any && (sel == 2'd0);
  assign wr_stat     = wr_any && (sel == 2'd1);
  assign wr_div      = wr_any && (sel == 2'd2);
  assign wr_ctrl     = wr_any && (sel == 2'd3);
  assign rd_data     = i_rd_en && (sel == 2'd0);
  assign unused_bits = ^{i_addr[1:0], i_din[31:16]};

  always_ff @(posedge i_clk or negedge i_rstb) begin
    if (!i_rstb) begin
      div_q <= 16'(DIV_RESET);
      rx_ie <= 1'b0;
      tx_ie <= 1'b0;
    end else begin
      if (wr_div)  div_q <= (i_din[15:0] < 16'd15) ? 16'd15 : i_din[15:0];
      if (wr_ctrl) begin
        rx_ie <= i_din[0];
        tx_ie <= i_din[1];
      end
    end
  end

`ifdef UART_LOOPBACK_EN
  always_ff @(posedge i_clk or negedge i_rstb) begin
    if (!i_rstb)      ctrl_loop <= 1'b0;
    else if (wr_ctrl) ctrl_loop <= i_din[8];
  end
`else
  assign ctrl_loop = 1'b0;
`endif

  // ---------------- TX FIFO ----------------
  logic [7:0]    fifo_mem [TXFIFO_DEPTH];
  logic [AW-1:0] wptr, rptr;
  logic [AW:0]   count;
  logic          fifo_full, fifo_empty, push, tx_pop;

  assign fifo_full  = (count == (AW+1)'(TXFIFO_DEPTH));
  assign fifo_empty = (count == '0);
  // A pop in the same cycle frees the slot, so a push into a full FIFO is still accepted.
  assign push       = wr_data && (!fifo_full || tx_pop);

  always_ff @(posedge i_clk) begin
    if (push) fifo_mem[wptr] <= i_din[7:0];
  end

  always_ff @(posedge i_clk or negedge i_rstb) begin
    if (!i_rstb) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push)   wptr <= wptr + 1'b1;
      if (tx_pop) rptr <= rptr + 1'b1;
      case ({push, tx_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // ---------------- Transmitter ----------------
  state_t      tx_state, tx_next;
  logic [15:0] tx_cnt;
  logic [2:0]  tx_bit;
  logic [7:0]  tx_shift;
  logic        tx_tick, tx_empty;

  assign tx_tick  = (tx_state != ST_IDLE) && (tx_cnt == '0);
  assign tx_pop   = !fifo_empty && ((tx_state == ST_IDLE) || ((tx_state == ST_STOP) && tx_tick));
  assign tx_empty = fifo_empty && (tx_state == ST_IDLE);

  always_ff @(posedge i_clk or negedge i_rstb) begin
    if (!i_rstb) tx_state <= ST_IDLE;
    else         tx_state <= tx_next;
  end

  always_comb begin
    tx_next = tx_state;
    case (tx_state)
      ST_IDLE:  if (!fifo_empty) tx_next = ST_START;
      ST_START: if (tx_tick) tx_next = ST_DATA;
      ST_DATA:  if (tx_tick && (tx_bit == 3'd7)) tx_next = ST_STOP;
      ST_STOP:  if (tx_tick) tx_next = fifo_empty ? ST_IDLE : ST_START;
      default:  tx_next = ST_IDLE;
    endcase
  end

  always_comb begin
    o_txd = 1'b1;
    case (tx_state)
      ST_START: o_txd = 1'b0;
      ST_DATA:  o_txd = tx_shift[0];
      default:  o_txd = 1'b1;
    endcase
  end

  // Bit timer reloads from DIV at every bit boundary, so a DIV write lands on the next bit.
  always_ff @(posedge i_clk or negedge i_rstb) begin
    if (!i_rstb) begin
      tx_cnt   <= '0;
      tx_bit   <= '0;
      tx_shift <= '1;
    end else begin
      if ((tx_state == ST_IDLE) || tx_tick) tx_cnt <= div_q;
      else                                  tx_cnt <= tx_cnt - 16'd1;
      if (tx_pop)                                tx_shift <= fifo_mem[rptr];
      else if ((tx_state == ST_DATA) && tx_tick) tx_shift <= {1'b0, tx_shift[7:1]};
      if (tx_state == ST_START)                  tx_bit <= '0;
      else if ((tx_state == ST_DATA) && tx_tick) tx_bit <= tx_bit + 3'd1;
    end
  end

  // ---------------- Receiver ----------------
  state_t      rx_state, rx_next;
  logic        rx_s1, rx_s2, rx_in, rx_prev, rx_fall, rx_tick, rx_done;
  logic [15:0] rx_cnt, half_m1;
  logic [2:0]  rx_bit;
  logic [7:0]  rx_shift, rx_byte;
  logic        rxv, ovr, fe;

  always_ff @(posedge i_clk or negedge i_rstb) begin
    if (!i_rstb) begin
      rx_s1   <= 1'b1;
      rx_s2   <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_s1   <= i_rxd;
      rx_s2   <= rx_s1;
      rx_prev <= rx_in;
    end
  end

  assign rx_in   = ctrl_loop ? o_txd : rx_s2;
  assign rx_fall = rx_prev && !rx_in;
  assign rx_tick = (rx_state != ST_IDLE) && (rx_cnt == '0);
  // (DIV+1)/2 - 1: first sample lands (DIV+1)/2 clocks after the detected edge.
  assign half_m1 = div_q[0] ? {1'b0, div_q[15:1]} : ({1'b0, div_q[15:1]} - 16'd1);

  always_ff @(posedge i_clk or negedge i_rstb) begin
    if (!i_rstb) rx_state <= ST_IDLE;
    else         rx_state <= rx_next;
  end

  always_comb begin
    rx_next = rx_state;
    case (rx_state)
      ST_IDLE:  if (rx_fall) rx_next = ST_START;
      ST_START: if (rx_tick) rx_next = rx_in ? ST_IDLE : ST_DATA;
      ST_DATA:  if (rx_tick && (rx_bit == 3'd7)) rx_next = ST_STOP;
      ST_STOP:  if (rx_tick) rx_next = ST_IDLE;
      default:  rx_next = ST_IDLE;
    endcase
  end

  always_comb begin
    rx_done = (rx_state == ST_STOP) && rx_tick;
  end

  always_ff @(posedge i_clk or negedge i_rstb) begin
    if (!i_rstb) begin
      rx_cnt   <= '0;
      rx_bit   <= '0;
      rx_shift <= '0;
    end else begin
      if (rx_state == ST_IDLE) rx_cnt <= half_m1;
      else if (rx_tick)        rx_cnt <= div_q;
      else                     rx_cnt <= rx_cnt - 16'd1;
      if (rx_state == ST_START) rx_bit <= '0;
      else if ((rx_state == ST_DATA) && rx_tick) begin
        rx_bit   <= rx_bit + 3'd1;
        rx_shift <= {rx_in, rx_shift[7:1]};
      end
    end
  end

  // A DATA read coinciding with delivery frees the buffer, so the new byte is taken without OVR.
  always_ff @(posedge i_clk or negedge i_rstb) begin
    if (!i_rstb) begin
      rx_byte <= '0;
      rxv     <= 1'b0;
      ovr     <= 1'b0;
      fe      <= 1'b0;
    end else begin
      if (rx_done && (!rxv || rd_data)) rx_byte <= rx_shift;
      if (rx_done)      rxv <= 1'b1;
      else if (rd_data) rxv <= 1'b0;
      if (rx_done && rxv && !rd_data) ovr <= 1'b1;
      else if (wr_stat && i_din[3])   ovr <= 1'b0;
      if (rx_done && !rx_in)          fe <= 1'b1;
      else if (wr_stat && i_din[4])   fe <= 1'b0;
    end
  end

  // ---------------- Read data / interrupt ----------------
  logic [31:0] rd_mux;

  always_comb begin
    rd_mux = '0;
    case (sel)
      2'd0: rd_mux = {24'b0, rx_byte};
      2'd1: rd_mux = {27'b0, fe, ovr, rxv, tx_empty, fifo_full};
      2'd2: rd_mux = {16'b0, div_q};
      2'd3: rd_mux = {23'b0, ctrl_loop, 6'b0, tx_ie, rx_ie};
      default: rd_mux = '0;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rstb) begin
    if (!i_rstb) begin
      o_dout <= '0;
      o_irq  <= 1'b0;
    end else begin
      if (i_rd_en) o_dout <= rd_mux;
      o_irq <= (rx_ie && rxv) || (tx_ie && tx_empty);
    end
  end

endmodule

// File: tb/tb_uart_mm.sv
// Directed self-checking bench for uart_mm (DIV=15 frames, 16 clocks per bit).
module tb_uart_mm;

  logic        i_clk = 1'b0;
  logic        i_rstb = 1'b0;
  logic [3:0]  i_addr = '0;
  logic [31:0] i_din = '0;
  logic [3:0]  i_wr_en = '0;
  logic        i_rd_en = 1'b0;
  logic        i_rxd = 1'b1;
  logic [31:0] o_dout;
  logic        o_irq;
  logic        o_txd;

  int n_vec = 0;
  int n_err = 0;

  uart_mm #(.TXFIFO_DEPTH(4), .DIV_RESET(433)) dut (
    .i_clk   (i_clk),
    .i_rstb  (i_rstb),
    .i_addr  (i_addr),
    .i_din   (i_din),
    .i_wr_en (i_wr_en),
    .i_rd_en (i_rd_en),
    .o_dout  (o_dout),
    .o_irq   (o_irq),
    .o_txd   (o_txd),
    .i_rxd   (i_rxd)
  );

  always #5 i_clk = ~i_clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge i_clk);
  endtask

  task automatic wr(input logic [3:0] a, input logic [31:0] d);
    i_addr = a; i_din = d; i_wr_en = 4'hF;
    @(negedge i_clk);
    i_wr_en = '0;
  endtask

  task automatic rd(input logic [3:0] a);
    i_addr = a; i_rd_en = 1'b1;
    @(negedge i_clk);
    i_rd_en = 1'b0;
  endtask

  // Called on the first cycle of a start bit plus 'pre' cycles; ends on the stop-bit midpoint.
  task automatic expect_frame(input logic [7:0] b, input int pre);
    logic [7:0] bb;
    bb = b;
    if (pre == 0) chk("tx_start_edge", {31'b0, o_txd}, 32'd0);
    tick(8 - pre);
    chk("tx_start", {31'b0, o_txd}, 32'd0);
    for (int k = 0; k < 8; k++) begin
      tick(16);
      chk("tx_bit", {31'b0, o_txd}, {31'b0, bb[k]});
    end
    tick(16);
    chk("tx_stop", {31'b0, o_txd}, 32'd1);
  endtask

  // Drives one 160-clock RX frame; optionally performs one bus access after hk_at edges.
  task automatic rx_frame(input logic [7:0] b, input logic stop, input int hk_at,
                          input logic [3:0] hk_addr, input logic [3:0] hk_wr,
                          input logic hk_rd, input logic [31:0] hk_din);
    logic [9:0] fr;
    fr = {stop, b, 1'b0};
    for (int c = 0; c < 160; c++) begin
      i_rxd = fr[c / 16];
      if (c == hk_at) begin
        i_addr = hk_addr; i_din = hk_din; i_wr_en = hk_wr; i_rd_en = hk_rd;
      end else begin
        i_wr_en = '0; i_rd_en = 1'b0;
      end
      @(negedge i_clk);
    end
    i_wr_en = '0; i_rd_en = 1'b0; i_rxd = 1'b1;
  endtask

  initial begin
    tick(3);
    chk("rst_dout", o_dout, 32'h0);
    chk("rst_irq", {31'b0, o_irq}, 32'd0);
    chk("rst_txd", {31'b0, o_txd}, 32'd1);
    i_rstb = 1'b1;
    tick(2);
    rd(4'h4); chk("rst_status", o_dout, 32'h02);
    rd(4'h8); chk("rst_div", o_dout, 32'd433);
    rd(4'hC); chk("rst_ctrl", o_dout, 32'h0);
    wr(4'h8, 32'd3);
    rd(4'h8); chk("div_clamp", o_dout, 32'd15);

    // Single TX frame 0xA5
    wr(4'h0, 32'hA5);
    chk("tx_pre_start", {31'b0, o_txd}, 32'd1);
    tick(1);
    expect_frame(8'hA5, 0);
    tick(7);
    rd(4'h4); chk("tx_busy_end", o_dout, 32'h00);
    rd(4'h4); chk("tx_empty_back", o_dout, 32'h02);

    // Five back-to-back bytes into a 4-deep FIFO; the sixth is dropped
    for (int i = 1; i <= 6; i++) wr(4'h0, 32'(i));
    rd(4'h4); chk("tx_full", o_dout, 32'h01);
    expect_frame(8'h01, 5);
    for (int i = 2; i <= 5; i++) begin
      tick(8);
      expect_frame(8'(i), 0);
    end
    tick(8);
    chk("tx_idle_after5", {31'b0, o_txd}, 32'd1);
    rd(4'h4); chk("tx_drained", o_dout, 32'h02);
    tick(20);
    chk("tx_6th_dropped", {31'b0, o_txd}, 32'd1);

    // RX 0x3C, STATUS read in the delivery cycle still sees RXV=0
    rx_frame(8'h3C, 1'b1, 154, 4'h4, 4'h0, 1'b1, 32'h0);
    chk("rx_rd_at_deliver", o_dout, 32'h02);
    rd(4'h4); chk("rx_status", o_dout, 32'h06);
    rd(4'h0); chk("rx_data", o_dout, 32'h3C);
    tick(3);
    chk("dout_hold", o_dout, 32'h3C);
    rd(4'h4); chk("rx_rxv_clr", o_dout, 32'h02);

    // Overrun
    rx_frame(8'h11, 1'b1, -1, 4'h0, 4'h0, 1'b0, 32'h0);
    rx_frame(8'h22, 1'b1, -1, 4'h0, 4'h0, 1'b0, 32'h0);
    rd(4'h4); chk("ovr_status", o_dout, 32'h0E);
    rd(4'h0); chk("ovr_data", o_dout, 32'h11);
    rd(4'h4); chk("ovr_rxv_clr", o_dout, 32'h0A);
    wr(4'h4, 32'h08);
    rd(4'h4); chk("ovr_clear", o_dout, 32'h02);

    // DATA read coinciding with delivery
    rx_frame(8'h44, 1'b1, -1, 4'h0, 4'h0, 1'b0, 32'h0);
    rx_frame(8'h55, 1'b1, 154, 4'h0, 4'h0, 1'b1, 32'h0);
    chk("rdd_old_byte", o_dout, 32'h44);
    rd(4'h4); chk("rdd_status", o_dout, 32'h06);
    rd(4'h0); chk("rdd_new_byte", o_dout, 32'h55);

    // OVR set and write-1-clear in the same cycle
    rx_frame(8'h66, 1'b1, -1, 4'h0, 4'h0, 1'b0, 32'h0);
    rx_frame(8'h77, 1'b1, 154, 4'h4, 4'hF, 1'b0, 32'h08);
    rd(4'h4); chk("set_wins", o_dout, 32'h0E);
    rd(4'h0); chk("set_wins_data", o_dout, 32'h66);
    wr(4'h4, 32'h08);
    rd(4'h4); chk("set_wins_clr", o_dout, 32'h02);

    // Framing error, then a short glitch
    rx_frame(8'h96, 1'b0, -1, 4'h0, 4'h0, 1'b0, 32'h0);
    rd(4'h4); chk("fe_status", o_dout, 32'h16);
    rd(4'h0); chk("fe_data", o_dout, 32'h96);
    wr(4'h4, 32'h10);
    rd(4'h4); chk("fe_clear", o_dout, 32'h02);
    i_rxd = 1'b0;
    tick(3);
    i_rxd = 1'b1;
    tick(30);
    rd(4'h4); chk("glitch", o_dout, 32'h02);

    // Control register and interrupt
    wr(4'hC, 32'h101);
`ifdef UART_LOOPBACK_EN
    rd(4'hC); chk("ctrl_rb", o_dout, 32'h101);
`else
    rd(4'hC); chk("ctrl_rb", o_dout, 32'h001);
`endif
    wr(4'hC, 32'h002);
    tick(2);
    chk("irq_txempty", {31'b0, o_irq}, 32'd1);
    wr(4'hC, 32'h001);
    tick(2);
    chk("irq_off", {31'b0, o_irq}, 32'd0);
    rx_frame(8'h5A, 1'b1, -1, 4'h0, 4'h0, 1'b0, 32'h0);
    chk("irq_rx", {31'b0, o_irq}, 32'd1);
    rd(4'h0); chk("irq_rx_data", o_dout, 32'h5A);
    tick(1);
    chk("irq_rx_clr", {31'b0, o_irq}, 32'd0);

    // Reset mid-frame
    wr(4'h0, 32'h77);
    wr(4'h0, 32'h78);
    tick(40);
    i_rstb = 1'b0;
    #1;
    chk("rst_mid_txd", {31'b0, o_txd}, 32'd1);
    chk("rst_mid_dout", o_dout, 32'h0);
    tick(2);
    i_rstb = 1'b1;
    tick(1);
    rd(4'h4); chk("rst_mid_status", o_dout, 32'h02);
    rd(4'h8); chk("rst_mid_div", o_dout, 32'd433);
    tick(30);
    chk("rst_fifo_empty", {31'b0, o_txd}, 32'd1);

`ifdef UART_LOOPBACK_EN
    wr(4'h8, 32'd15);
    wr(4'hC, 32'h101);
    wr(4'h0, 32'h5A);
    tick(175);
    chk("lb_irq", {31'b0, o_irq}, 32'd1);
    rd(4'h4); chk("lb_status", o_dout, 32'h06);
    rd(4'h0); chk("lb_data", o_dout, 32'h5A);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
